// File: rtl/rgb_to_yuv.sv
// RGB pixel pairs to a 4:2:2 U,Y0,V,Y1 byte stream; RGB_TO_YUV_CHROMA_AVG_EN averages chroma over the pair.
// Latency: U one cycle after the pixel1 edge, then Y0, V and Y1 on consecutive cycles.
// Backpressure: busy is high for the four output cycles; in_en is ignored (not queued) while busy.
module rgb_to_yuv #(
  parameter int               FRAC_BITS = 3,
  parameter logic signed [5:0] YR = 6'sd2,
  parameter logic signed [5:0] YG = 6'sd5,
  parameter logic signed [5:0] YB = 6'sd1,
  parameter logic signed [5:0] UR = -6'sd1,
  parameter logic signed [5:0] UG = -6'sd2,
  parameter logic signed [5:0] UB = 6'sd3,
  parameter logic signed [5:0] VR = 6'sd4,
  parameter logic signed [5:0] VG = -6'sd3,
  parameter logic signed [5:0] VB = -6'sd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [23:0] rgb_in,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  yuv_out
);

  localparam logic [2:0] S_P0  = 3'd0;
  localparam logic [2:0] S_P1  = 3'd1;
  localparam logic [2:0] S_OU  = 3'd2;
  localparam logic [2:0] S_OY0 = 3'd3;
  localparam logic [2:0] S_OV  = 3'd4;
  localparam logic [2:0] S_OY1 = 3'd5;

  localparam logic signed [15:0] HALF = 16'sd1 <<< (FRAC_BITS - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [23:0] pix0;
  logic [7:0]  y0_q;
  logic [7:0]  y1_q;
  logic [7:0]  u_q;
  logic [7:0]  v_q;

  function automatic logic signed [15:0] mac(
    input logic signed [5:0] cr,
    input logic signed [5:0] cg,
    input logic signed [5:0] cb,
    input logic [23:0]       px
  );
    logic signed [15:0] r, g, b;
    logic signed [15:0] kr, kg, kb;
    r  = {8'd0, px[23:16]};
    g  = {8'd0, px[15:8]};
    b  = {8'd0, px[7:0]};
    kr = {{10{cr[5]}}, cr};
    kg = {{10{cg[5]}}, cg};
    kb = {{10{cb[5]}}, cb};
    return kr * r + kg * g + kb * b;
  endfunction

  function automatic logic signed [15:0] round_acc(input logic signed [15:0] acc);
    return (acc + HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic [7:0] clamp_y(input logic signed [16:0] v);
    logic [7:0] res;
    if (v < 17'sd0)
      res = 8'h00;
    else if (v > 17'sd255)
      res = 8'hFF;
    else
      res = v[7:0];
    return res;
  endfunction

  function automatic logic [7:0] clamp_c(input logic signed [16:0] v);
    logic [7:0] res;
    if (v < -17'sd128)
      res = 8'h80;
    else if (v > 17'sd127)
      res = 8'h7F;
    else
      res = v[7:0];
    return res;
  endfunction

  // Luma for both pixels of the pair
  logic signed [15:0] y_acc0, y_acc1;
  logic signed [15:0] y_rnd0, y_rnd1;
  logic [7:0]         y0_c, y1_c;

  assign y_acc0 = mac(YR, YG, YB, pix0);
  assign y_acc1 = mac(YR, YG, YB, rgb_in);
  assign y_rnd0 = round_acc(y_acc0);
  assign y_rnd1 = round_acc(y_acc1);
  assign y0_c   = clamp_y({y_rnd0[15], y_rnd0});
  assign y1_c   = clamp_y({y_rnd1[15], y_rnd1});

  logic signed [15:0] u_acc0, v_acc0;
  logic [7:0]         u_c, v_c;

  assign u_acc0 = mac(UR, UG, UB, pix0);
  assign v_acc0 = mac(VR, VG, VB, pix0);

`ifdef RGB_TO_YUV_CHROMA_AVG_EN
  localparam logic signed [16:0] HALF2 = 17'sd1 <<< FRAC_BITS;

  logic signed [15:0] u_acc1, v_acc1;
  logic signed [16:0] u_sum, v_sum;
  logic signed [16:0] u_rnd, v_rnd;

  assign u_acc1 = mac(UR, UG, UB, rgb_in);
  assign v_acc1 = mac(VR, VG, VB, rgb_in);
  // Sum needs the extra bit before halving, or large opposite-sign pairs wrap
  assign u_sum  = {u_acc0[15], u_acc0} + {u_acc1[15], u_acc1};
  assign v_sum  = {v_acc0[15], v_acc0} + {v_acc1[15], v_acc1};
  assign u_rnd  = (u_sum + HALF2) >>> (FRAC_BITS + 1);
  assign v_rnd  = (v_sum + HALF2) >>> (FRAC_BITS + 1);
  assign u_c    = clamp_c(u_rnd);
  assign v_c    = clamp_c(v_rnd);
`else
  logic signed [15:0] u_rnd, v_rnd;

  assign u_rnd = round_acc(u_acc0);
  assign v_rnd = round_acc(v_acc0);
  assign u_c   = clamp_c({u_rnd[15], u_rnd});
  assign v_c   = clamp_c({v_rnd[15], v_rnd});
`endif

  always_comb begin
    state_nxt = S_P0;
    case (state)
      S_P0:    state_nxt = in_en ? S_P1 : S_P0;
      S_P1:    state_nxt = in_en ? S_OU : S_P1;
      S_OU:    state_nxt = S_OY0;
      S_OY0:   state_nxt = S_OV;
      S_OV:    state_nxt = S_OY1;
      S_OY1:   state_nxt = S_P0;
      default: state_nxt = S_P0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_P0;
      pix0  <= 24'd0;
      y0_q  <= 8'd0;
      y1_q  <= 8'd0;
      u_q   <= 8'd0;
      v_q   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == S_P0 && in_en)
        pix0 <= rgb_in;
      if (state == S_P1 && in_en) begin
        y0_q <= y0_c;
        y1_q <= y1_c;
        u_q  <= u_c;
        v_q  <= v_c;
      end
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for an edge
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    yuv_out   = 8'h00;
    case (state)
      S_OU:    begin busy = 1'b1; out_valid = 1'b1; yuv_out = u_q;  end
      S_OY0:   begin busy = 1'b1; out_valid = 1'b1; yuv_out = y0_q; end
      S_OV:    begin busy = 1'b1; out_valid = 1'b1; yuv_out = v_q;  end
      S_OY1:   begin busy = 1'b1; out_valid = 1'b1; yuv_out = y1_q; end
      default: begin busy = 1'b0; out_valid = 1'b0; yuv_out = 8'h00; end
    endcase
  end

endmodule

// File: tb/tb_rgb_to_yuv.sv
// Randomised bench for rgb_to_yuv against a pair-level arithmetic reference model.
module tb_rgb_to_yuv;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [23:0] rgb_in;
  logic        busy;
  logic        out_valid;
  logic [7:0]  yuv_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending pixel0 and the four bytes still owed
  bit          m_have0   = 1'b0;
  logic [23:0] m_p0      = 24'd0;
  int          m_blocked = 0;
  logic [7:0]  m_bytes [4];
  bit          checking  = 1'b0;
  logic [31:0] dut_hist  = 32'd0;

  rgb_to_yuv dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .rgb_in    (rgb_in),
    .busy      (busy),
    .out_valid (out_valid),
    .yuv_out   (yuv_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // floor((a + d/2) / d) with d = 2^sh
  function automatic int round_div(input int a, input int sh);
    int d, n, q;
    d = 1 << sh;
    n = a + d / 2;
    q = n / d;
    if (n < 0 && (n % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [7:0] sat_y(input int v);
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return v[7:0];
  endfunction

  function automatic logic [7:0] sat_c(input int v);
    if (v < -128) return 8'h80;
    if (v > 127) return 8'h7F;
    return v[7:0];
  endfunction

  // Returns {U, Y0, V, Y1}
  function automatic logic [31:0] model(input logic [23:0] p0, input logic [23:0] p1);
    int r0, g0, b0, r1, g1, b1;
    int y0, y1, u, v;
    r0 = int'(p0[23:16]); g0 = int'(p0[15:8]); b0 = int'(p0[7:0]);
    r1 = int'(p1[23:16]); g1 = int'(p1[15:8]); b1 = int'(p1[7:0]);
    y0 = round_div(2 * r0 + 5 * g0 + b0, 3);
    y1 = round_div(2 * r1 + 5 * g1 + b1, 3);
`ifdef RGB_TO_YUV_CHROMA_AVG_EN
    u = round_div((-r0 - 2 * g0 + 3 * b0) + (-r1 - 2 * g1 + 3 * b1), 4);
    v = round_div((4 * r0 - 3 * g0 - b0) + (4 * r1 - 3 * g1 - b1), 4);
`else
    u = round_div(-r0 - 2 * g0 + 3 * b0, 3);
    v = round_div(4 * r0 - 3 * g0 - b0, 3);
`endif
    return {sat_c(u), sat_y(y0), sat_c(v), sat_y(y1)};
  endfunction

  task automatic model_reset();
    m_have0   = 1'b0;
    m_blocked = 0;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model with what the DUT saw
  task automatic cycle(input bit en, input logic [23:0] px);
    logic [31:0] b;
    in_en  = en;
    rgb_in = px;
    @(posedge clk);
    if (m_blocked > 0) begin
      m_blocked--;
    end else if (en) begin
      if (!m_have0) begin
        m_p0    = px;
        m_have0 = 1'b1;
      end else begin
        b = model(m_p0, px);
        m_bytes[0] = b[31:24];
        m_bytes[1] = b[23:16];
        m_bytes[2] = b[15:8];
        m_bytes[3] = b[7:0];
        m_have0   = 1'b0;
        m_blocked = 4;
      end
    end
    #1;
  endtask

  task automatic send_pair(input string name, input logic [23:0] p0, input logic [23:0] p1,
                           input logic [31:0] lit);
    cycle(1'b1, p0);
    cycle(1'b1, p1);
    for (int i = 0; i < 4; i++) cycle(1'b0, $urandom);
    chk(name, dut_hist, lit);
  endtask

  function automatic logic [7:0] rand_chan();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return 8'h00;
    if (s == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  // Single compare process against the model's expectation for the current cycle
  always @(negedge clk) begin
    if (checking && !reset) begin
      if (m_blocked > 0) begin
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd1);
        chk("yuv_out", {24'd0, yuv_out}, {24'd0, m_bytes[4 - m_blocked]});
        dut_hist = {dut_hist[23:0], yuv_out};
      end else begin
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_yuv", {24'd0, yuv_out}, 32'd0);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    in_en  = 1'b0;
    rgb_in = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_yuv", {24'd0, yuv_out}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    checking = 1'b1;

    // Pin the model with hand-worked results
    chk("model_ext", model(24'hFFFFFF, 24'h000000), 32'h00FF0000);
`ifdef RGB_TO_YUV_CHROMA_AVG_EN
    chk("model_clamp", model(24'hFF0000, 24'h00FF00), 32'hD040109F);
`else
    chk("model_clamp", model(24'hFF0000, 24'h00FF00), 32'hE0407F9F);
`endif
    chk("model_blue", model(24'h0000FF, 24'h0000FF), 32'h6020E020);

    send_pair("extremes", 24'hFFFFFF, 24'h000000, 32'h00FF0000);
`ifdef RGB_TO_YUV_CHROMA_AVG_EN
    send_pair("clamp", 24'hFF0000, 24'h00FF00, 32'hD040109F);
`else
    send_pair("clamp", 24'hFF0000, 24'h00FF00, 32'hE0407F9F);
`endif
    send_pair("blue", 24'h0000FF, 24'h0000FF, 32'h6020E020);

    // Gap between pixel0 and pixel1
    cycle(1'b1, 24'hFF0000);
    for (int i = 0; i < 3; i++) cycle(1'b0, $urandom);
    cycle(1'b1, 24'h00FF00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 24'h123456);
`ifdef RGB_TO_YUV_CHROMA_AVG_EN
    chk("gap", dut_hist, 32'hD040109F);
`else
    chk("gap", dut_hist, 32'hE0407F9F);
`endif

    // in_en held high through busy: junk ignored, next pair starts right after Y1
    cycle(1'b1, 24'hFFFFFF);
    cycle(1'b1, 24'h000000);
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom);
    cycle(1'b1, 24'h0000FF);
    cycle(1'b1, 24'h0000FF);
    for (int i = 0; i < 4; i++) cycle(1'b0, 24'h0);
    chk("busy_ignore", dut_hist, 32'h6020E020);

    // Reset while V is on the output
    cycle(1'b1, 24'hFFFFFF);
    cycle(1'b1, 24'h000000);
    cycle(1'b0, 24'h0);
    cycle(1'b0, 24'h0);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_yuv", {24'd0, yuv_out}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0, 24'h0);
    send_pair("post_rst", 24'h0000FF, 24'h0000FF, 32'h6020E020);

    // Random traffic with channel extremes mixed in
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) < 7, {rand_chan(), rand_chan(), rand_chan()});
    for (int i = 0; i < 8; i++) cycle(1'b0, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_to_yuv.md
Name: rgb_to_yuv

Overview:
- Colour-space encoder inside the CTE colour transform engine. It is the reverse-direction companion of the YUV-to-RGB decoder.
- Accepts RGB pixels in pairs, one 24-bit pixel per enabled cycle.
- Emits a 4:2:2 byte stream in the order U, Y0, V, Y1 on an 8-bit output. This is the same byte order the decoder consumes.
- Fixed-point coefficients in 1/2^FRAC_BITS units, with rounding and clamping.

Parameters:
- FRAC_BITS, 3: fractional bits of all coefficients; the result is (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS.
- YR, YG, YB, 2, 5, 1: luma coefficients (signed, 6-bit).
- UR, UG, UB, -1, -2, 3: U coefficients (signed, 6-bit).
- VR, VG, VB, 4, -3, -1: V coefficients (signed, 6-bit).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- in_en  input  1  rgb_in is valid this cycle; honoured only while busy=0.
- rgb_in  input  24  pixel {R[23:16], G[15:8], B[7:0]}, unsigned.
- busy  output  1  block cannot accept a pixel this cycle.
- out_valid  output  1  yuv_out carries a valid byte this cycle.
- yuv_out  output  8  Y is unsigned 0..255; U and V are two's complement -128..127.

Behaviour:
- Reset is asynchronous and active-high, and overrides everything, including mid-operation:
  - state = S_P0.
  - busy = 0, out_valid = 0, yuv_out = 0.
  - All pixel and result registers are cleared.
- States, encoded in 3 bits:
  - S_P0: accept pixel0. busy=0.
  - S_P1: accept pixel1. busy=0.
  - S_OU: output U. busy=1, out_valid=1.
  - S_OY0: output Y0. busy=1, out_valid=1.
  - S_OV: output V. busy=1, out_valid=1.
  - S_OY1: output Y1. busy=1, out_valid=1.
- Transitions:
  - S_P0 -(in_en)-> S_P1
  - S_P1 -(in_en)-> S_OU -> S_OY0 -> S_OV -> S_OY1 -> S_P0
  - Without in_en, S_P0 and S_P1 hold indefinitely. Pixel0 is retained across gaps; in_en low does not reset the pair.
  - Unused encodings go to S_P0.
- Capture:
  - S_P0 with in_en: rgb_in is registered as pixel0.
  - S_P1 with in_en: Y0, Y1, U and V are computed combinationally from pixel0 and the live rgb_in, then registered into result registers on that edge.
- Latency: U appears on yuv_out in the first cycle after the edge that captured pixel1. Y0, V and Y1 follow on consecutive cycles. out_valid is high for exactly 4 cycles per pair.
- in_en while busy=1 is ignored; no data is lost or queued. The earliest next pixel0 is accepted in the cycle after S_OY1.
- Output is muxed from the result registers by state. yuv_out = 0 whenever out_valid = 0.
- Arithmetic:
  - Channels are zero-extended to 16-bit signed; coefficients are sign-extended.
  - acc = C_R*R + C_G*G + C_B*B, 16-bit signed.
  - Round half up: add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS.
- Clamping:
  - Y: <0 becomes 0; >255 becomes 255.
  - U, V: <-128 becomes -128 (0x80); >127 becomes 127 (0x7F).
  - With the default coefficients, V = 128 occurs (R=255, G=B=0) and must clamp to 0x7F.
- Chroma source: U and V come from pixel0 only, unless the optional feature below is enabled.

Optional Feature:
- Macro: RGB_TO_YUV_CHROMA_AVG_EN.
- Defined: U and V use acc0 + acc1 (the sums over both pixels), rounded as (sum + 2^FRAC_BITS) >>> (FRAC_BITS+1), then clamped as above. This requires a 17-bit intermediate.
- Undefined: U and V come from pixel0 only, and the pixel1 chroma multipliers are not instantiated.
- Y computation, timing and handshake are identical in both builds.

Test Plan:
- Reset: assert reset at an arbitrary time -> same cycle busy=0, out_valid=0, yuv_out=0x00. After release, the first in_en pixel is treated as pixel0.
- Extremes: pixel0=0xFFFFFF, pixel1=0x000000 -> bytes 0x00, 0xFF, 0x00, 0x00 on 4 consecutive out_valid cycles starting one cycle after the pixel1 edge.
- Clamp and rounding: pixel0=0xFF0000, pixel1=0x00FF00 -> U=0xE0, Y0=0x40, V=0x7F (clamped from 128), Y1=0x9F. With RGB_TO_YUV_CHROMA_AVG_EN: U=0xD0, V=0x10.
- Blue pair: pixel0=pixel1=0x0000FF -> U=0x60, Y0=0x20, V=0xE0, Y1=0x20.
- Handshake:
  - Pixel0, then in_en low for 3 cycles, then pixel1 -> state holds in S_P1 and the output matches the no-gap result.
  - in_en held high with changing rgb_in during busy -> those pixels are ignored, and the next pair starts the cycle after Y1.
- Reset mid-output: assert reset during S_OV -> out_valid drops immediately, Y1 is never emitted, and the next pair is decoded correctly from a clean state.
